// File: rtl/i2c_write_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : i2c_write_sequencer                                               |
// | Brief  : I2C master write controller (START, addr+W, N data bytes, STOP)   |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module i2c_write_sequencer #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [6:0] addr,
    input  logic [2:0] nbytes,
    input  logic [7:0] wdata,
    input  logic       wdata_valid,
    output logic       wdata_ready,
    output logic       scl_o,
    output logic       sda_o,
    input  logic       sda_i,
    output logic       busy,
    output logic       done,
    output logic       nack
);
    localparam int                 c_DIV_W    = $clog2(CLK_DIV);
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_START = 3'd1;
    localparam logic [2:0] c_ST_ADDR  = 3'd2;
    localparam logic [2:0] c_ST_AACK  = 3'd3;
    localparam logic [2:0] c_ST_WAIT  = 3'd4;
    localparam logic [2:0] c_ST_DATA  = 3'd5;
    localparam logic [2:0] c_ST_DACK  = 3'd6;
    localparam logic [2:0] c_ST_STOP  = 3'd7;

    logic [2:0]         r_state, w_state;
    logic [c_DIV_W-1:0] r_div, w_div;
    logic [1:0]         r_q, w_q;
    logic [2:0]         r_bit, w_bit;
    logic [7:0]         r_shift, w_shift;
    logic [7:0]         r_data, w_data;
    logic               r_have, w_have;
    logic [2:0]         r_left, w_left;
    logic               r_ack, w_ack;
    logic               r_nack, w_nack;
    logic               r_done, w_done;
    logic               r_busy, w_busy;
    logic               r_ready, w_ready;
    logic               r_scl, w_scl;
    logic               r_sda, w_sda;
    logic               w_hs, w_qend, w_slot_end, w_is_ack;

    always_comb begin
        w_state    = r_state;
        w_div      = r_div;
        w_q        = r_q;
        w_bit      = r_bit;
        w_shift    = r_shift;
        w_data     = r_data;
        w_have     = r_have;
        w_left     = r_left;
        w_ack      = r_ack;
        w_nack     = r_nack;
        w_done     = 1'b0;
        w_hs       = r_ready & wdata_valid;
        w_qend     = (r_div == c_DIV_LAST);
        w_slot_end = w_qend && (r_q == 2'd3);

        // IDLE and WAIT hold the divider at zero; every other state runs it
        if (r_state != c_ST_IDLE && r_state != c_ST_WAIT) begin
            w_div = w_qend ? '0 : r_div + 1'b1;
            if (w_qend) begin
                w_q = r_q + 2'd1;
            end
        end

        if (w_hs) begin
            w_data = wdata;
            w_have = 1'b1;
            w_left = r_left - 3'd1;
        end

        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    w_state = c_ST_START;
                    w_div   = '0;
                    w_q     = 2'd0;
                    w_bit   = 3'd0;
                    w_shift = {addr, 1'b0};
                    w_left  = nbytes;
                    w_have  = 1'b0;
                    w_ack   = 1'b0;
                    w_nack  = 1'b0;
                end
            end
            c_ST_START: begin
                if (w_slot_end) w_state = c_ST_ADDR;
            end
            c_ST_ADDR, c_ST_DATA: begin
                if (w_slot_end) begin
                    if (r_bit == 3'd7) begin
                        w_state = (r_state == c_ST_ADDR) ? c_ST_AACK : c_ST_DACK;
                    end else begin
                        w_bit   = r_bit + 3'd1;
                        w_shift = {r_shift[6:0], 1'b0};
                    end
                end
            end
            c_ST_AACK, c_ST_DACK: begin
                if (w_qend && r_q == 2'd2) w_ack = sda_i;
                if (w_slot_end) begin
                    w_bit = 3'd0;
                    if (r_ack || (!w_have && w_left == 3'd0)) begin
                        w_state = c_ST_STOP;
                    end else if (w_have) begin
                        w_state = c_ST_DATA;
                        w_shift = w_data;
                        w_have  = 1'b0;
                    end else begin
                        w_state = c_ST_WAIT;
                    end
                end
            end
            c_ST_WAIT: begin
                if (w_hs) begin
                    w_state = c_ST_DATA;
                    w_shift = wdata;
                    w_have  = 1'b0;
                    w_div   = '0;
                    w_q     = 2'd0;
                end
            end
            default: begin
                if (w_slot_end) begin
                    w_state = c_ST_IDLE;
                    w_done  = 1'b1;
                    w_nack  = r_ack;
                end
            end
        endcase

        w_is_ack = (w_state == c_ST_AACK) || (w_state == c_ST_DACK);
        // ready opens only once the slave has ACKed, so a NACK never offers a byte
        w_ready  = ((w_is_ack && w_q == 2'd3 && !w_ack) || (w_state == c_ST_WAIT))
                   && (w_left != 3'd0) && !w_have;
        w_busy   = (w_state != c_ST_IDLE);

        case (w_state)
            c_ST_IDLE:            begin w_scl = 1'b1;  w_sda = 1'b1;            end
            c_ST_START:           begin w_scl = 1'b1;  w_sda = !w_q[1];         end
            c_ST_ADDR, c_ST_DATA: begin w_scl = w_q[1]; w_sda = w_shift[7];     end
            c_ST_AACK, c_ST_DACK: begin w_scl = w_q[1]; w_sda = 1'b1;           end
            c_ST_WAIT:            begin w_scl = 1'b0;  w_sda = 1'b1;            end
            default:              begin w_scl = w_q[1]; w_sda = (w_q == 2'd3);  end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= c_ST_IDLE;
            r_div   <= '0;
            r_q     <= 2'd0;
            r_bit   <= 3'd0;
            r_shift <= 8'd0;
            r_data  <= 8'd0;
            r_have  <= 1'b0;
            r_left  <= 3'd0;
            r_ack   <= 1'b0;
            r_nack  <= 1'b0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
            r_ready <= 1'b0;
            r_scl   <= 1'b1;
            r_sda   <= 1'b1;
        end else begin
            r_state <= w_state;
            r_div   <= w_div;
            r_q     <= w_q;
            r_bit   <= w_bit;
            r_shift <= w_shift;
            r_data  <= w_data;
            r_have  <= w_have;
            r_left  <= w_left;
            r_ack   <= w_ack;
            r_nack  <= w_nack;
            r_done  <= w_done;
            r_busy  <= w_busy;
            r_ready <= w_ready;
            r_scl   <= w_scl;
            r_sda   <= w_sda;
        end
    end

    assign wdata_ready = r_ready;
    assign scl_o       = r_scl;
    assign sda_o       = r_sda;
    assign busy        = r_busy;
    assign done        = r_done;
    assign nack        = r_nack;
endmodule
`default_nettype wire

// File: tb/tb_i2c_write_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_i2c_write_sequencer                                            |
// | Brief  : directed bench for i2c_write_sequencer with CLK_DIV = 4           |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_i2c_write_sequencer;
    logic       clk = 1'b0;
    logic       reset, start, wdata_valid, sda_i;
    logic [6:0] addr;
    logic [2:0] nbytes;
    logic [7:0] wdata;
    logic       wdata_ready, scl_o, sda_o, busy, done, nack;

    int errors = 0;
    int checks = 0;

    i2c_write_sequencer #(.CLK_DIV(4)) dut (
        .clk(clk), .reset(reset), .start(start), .addr(addr), .nbytes(nbytes),
        .wdata(wdata), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
        .scl_o(scl_o), .sda_o(sda_o), .sda_i(sda_i),
        .busy(busy), .done(done), .nack(nack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One transaction; cycle numbers count edges after the start-acceptance edge.
    task automatic run(input logic [6:0] a, input logic [2:0] n, input logic [7:0] d0, d1,
                       input logic sdai, input int valid_at, input bit hold, input int rst_at,
                       output int done_at, output logic nk, output logic [63:0] bits,
                       output int nbits, output int rdy, output int dcnt, output int waitbad,
                       output logic busy_after, output logic nack_c1, output logic [3:0] rst_snap);
        int   idx;
        logic hs, prev;
        done_at = -1; nk = 1'b0; bits = '0; nbits = 0; rdy = 0; dcnt = 0; waitbad = 0;
        busy_after = 1'b0; nack_c1 = 1'b1; rst_snap = 4'h0; idx = 0; prev = 1'b1;
        @(negedge clk);
        addr = a; nbytes = n; sda_i = sdai; wdata = d0;
        wdata_valid = (valid_at < 0) && (n != 3'd0);
        start = 1'b1;
        @(posedge clk); #1;
        start = hold;
        for (int cyc = 1; cyc <= 2000; cyc++) begin
            hs = wdata_valid & wdata_ready;
            @(posedge clk); #1;
            if (hs) begin
                idx++;
                wdata = (idx == 1) ? d1 : 8'h00;
                if (idx >= int'(n)) wdata_valid = 1'b0;
            end
            if (cyc == 1) nack_c1 = nack;
            if (rst_at >= 0 && cyc == rst_at + 1) begin
                rst_snap = {scl_o, sda_o, busy, done};
                reset = 1'b1;
                break;
            end
            if (cyc == rst_at) reset = 1'b0;
            if (cyc == valid_at) wdata_valid = 1'b1;
            if (wdata_ready) rdy++;
            if (!prev && scl_o) begin
                bits = {bits[62:0], sda_o};
                nbits++;
            end
            prev = scl_o;
            if (valid_at >= 0 && cyc >= 160 && cyc <= valid_at && !(scl_o == 1'b0 && sda_o == 1'b1))
                waitbad++;
            if (done) begin
                dcnt++;
                if (done_at < 0) begin
                    done_at = cyc;
                    nk = nack;
                end
            end
            if (done_at >= 0 && cyc == done_at + 1) busy_after = busy;
            if (done_at >= 0 && cyc >= done_at + 3) break;
        end
        start = 1'b0;
        wdata_valid = 1'b0;
    endtask

    int          done_at, nbits, rdy, dcnt, waitbad;
    logic        nk, busy_after, nack_c1;
    logic [63:0] bits;
    logic [3:0]  rst_snap;

    initial begin
        reset = 1'b0; start = 1'b0; wdata_valid = 1'b0; sda_i = 1'b1;
        addr = '0; nbytes = '0; wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {scl_o, sda_o, wdata_ready, busy, done, nack}, 6'b110000);
        reset = 1'b1;

        // T1: two bytes, pre-valid, all ACKed
        run(7'h50, 3'd2, 8'hA5, 8'h3C, 1'b0, -1, 1'b0, -1, done_at, nk, bits, nbits, rdy, dcnt,
            waitbad, busy_after, nack_c1, rst_snap);
        chk("t1_done_at", done_at, 464);
        chk("t1_nack", nk, 0);
        chk("t1_nbits", nbits, 28);
        chk("t1_bits", bits, {36'd0, 8'hA0, 1'b1, 8'hA5, 1'b1, 8'h3C, 1'b1, 1'b0});
        chk("t1_done_count", dcnt, 1);
        chk("t1_busy_after", busy_after, 0);

        // T2: address NACK
        run(7'h27, 3'd3, 8'h11, 8'h22, 1'b1, -1, 1'b0, -1, done_at, nk, bits, nbits, rdy, dcnt,
            waitbad, busy_after, nack_c1, rst_snap);
        chk("t2_done_at", done_at, 176);
        chk("t2_nack", nk, 1);
        chk("t2_ready_cycles", rdy, 0);
        chk("t2_bits", bits, {54'd0, 8'h4E, 1'b1, 1'b0});
        chk("t2_nack_hold", nack, 1);

        // T3: one byte offered 20 clks into the stretch
        run(7'h50, 3'd1, 8'h96, 8'h00, 1'b0, 179, 1'b0, -1, done_at, nk, bits, nbits, rdy, dcnt,
            waitbad, busy_after, nack_c1, rst_snap);
        chk("t3_nack_cleared", nack_c1, 0);
        chk("t3_done_at", done_at, 340);
        chk("t3_nack", nk, 0);
        chk("t3_wait_bad", waitbad, 0);
        chk("t3_bits", bits, {45'd0, 8'hA0, 1'b1, 8'h96, 1'b1, 1'b0});

        // T4: address-only probe
        run(7'h13, 3'd0, 8'hFF, 8'hFF, 1'b0, -1, 1'b0, -1, done_at, nk, bits, nbits, rdy, dcnt,
            waitbad, busy_after, nack_c1, rst_snap);
        chk("t4_done_at", done_at, 176);
        chk("t4_nack", nk, 0);
        chk("t4_ready_cycles", rdy, 0);
        chk("t4_bits", bits, {54'd0, 8'h26, 1'b1, 1'b0});

        // T5: reset in the middle of data bit 3, then a clean rerun of T1
        run(7'h50, 3'd2, 8'hA5, 8'h3C, 1'b0, -1, 1'b0, 212, done_at, nk, bits, nbits, rdy, dcnt,
            waitbad, busy_after, nack_c1, rst_snap);
        chk("t5_reset_snapshot", rst_snap, 4'b1100);
        run(7'h50, 3'd2, 8'hA5, 8'h3C, 1'b0, -1, 1'b0, -1, done_at, nk, bits, nbits, rdy, dcnt,
            waitbad, busy_after, nack_c1, rst_snap);
        chk("t5_rerun_done_at", done_at, 464);
        chk("t5_rerun_bits", bits, {36'd0, 8'hA0, 1'b1, 8'hA5, 1'b1, 8'h3C, 1'b1, 1'b0});

        // T6: start held high through the whole transaction
        run(7'h50, 3'd2, 8'hA5, 8'h3C, 1'b0, -1, 1'b1, -1, done_at, nk, bits, nbits, rdy, dcnt,
            waitbad, busy_after, nack_c1, rst_snap);
        chk("t6_done_at", done_at, 464);
        chk("t6_done_count", dcnt, 1);
        chk("t6_restart_busy", busy_after, 1);
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
